result_streamer: RTL and testbench

- Downstream of matmul. Drains the A×C result matrix from the output block_ram once matmul raises valid.
- Requantizes each OUT_BITS accumulator to BITS with round-half-up, arithmetic shift and saturation.
- Emits results in address order on a valid/ready stream, tagging row and matrix ends, so results can feed the next layer or leave the device.
- Hides the RAM's 1-cycle read latency under backpressure, and sustains 1 element/cycle while out_ready is held high.

---
 rtl/matmul_pkg.sv | 32 +++
 rtl/requant_sat.sv | 15 +
 rtl/result_streamer.sv | 122 ++++++++++++
 tb/tb_result_streamer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and the requantisation arithmetic for the matmul result path.
package matmul_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

    // Wide enough that adding the rounding bias to any accumulator up to 63 bits cannot overflow.
    localparam int REQ_W = 64;

    function automatic logic signed [REQ_W-1:0] requant(input logic signed [REQ_W-1:0] x,
                                                        input int shift,
                                                        input int bits);
        logic signed [REQ_W-1:0] one;
        logic signed [REQ_W-1:0] r;
        logic signed [REQ_W-1:0] hi;
        logic signed [REQ_W-1:0] lo;
        one = REQ_W'(1);
        r   = x;
        if (shift > 0) begin
            r = r + (one <<< (shift - 1));
        end
        r  = r >>> shift;
        hi = (one <<< (bits - 1)) - one;
        lo = -(one <<< (bits - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational round-half-up, arithmetic shift and saturate of one accumulator.
module requant_sat
    import matmul_pkg::*;
#(
    parameter int OUT_BITS = 32,
    parameter int BITS     = 8,
    parameter int SHIFT    = 8
) (
    input  logic signed [OUT_BITS-1:0] acc_i,
    output logic signed [BITS-1:0]     q_o
);

    assign q_o = BITS'(requant(REQ_W'(acc_i), SHIFT, BITS));

endmodule

// File: rtl/result_streamer.sv
// Drains the matmul result RAM in address order, requantises each entry and
// streams it out on valid/ready with row/matrix end tags.
module result_streamer
    import matmul_pkg::*;
#(
    parameter int A        = 16,
    parameter int C        = 24,
    parameter int BITS     = 8,
    parameter int OUT_BITS = 32,
    parameter int SHIFT    = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic [$clog2(A*C)-1:0]               m3_rd_addr,
    input  logic signed [OUT_BITS-1:0]           m3_rd_data,
    output logic signed [BITS-1:0]               out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_row_last,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done
);

    localparam int M3_L = A * C;
    localparam int AW   = $clog2(M3_L);
    localparam int CW   = $clog2(M3_L + 1);
    localparam int COLW = (C > 1) ? $clog2(C) : 1;

    state_e                 state_q;
    logic [CW-1:0]          rd_cnt_q;
    logic [AW-1:0]          emit_cnt_q;
    logic [COLW-1:0]        col_q;
    logic                   vld_p1_q;
    logic signed [BITS-1:0] data_p1;
    logic signed [BITS-1:0] fifo_q [2];
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [1:0]             cnt_q;
    logic                   pop;
    logic                   issue;
    logic [2:0]             pending;

    requant_sat #(
        .OUT_BITS(OUT_BITS),
        .BITS    (BITS),
        .SHIFT   (SHIFT)
    ) u_requant (
        .acc_i(m3_rd_data),
        .q_o  (data_p1)
    );

    // An entry popped this cycle is already free, so the pipe never stalls at full rate.
    assign pop     = out_valid & out_ready;
    assign pending = 3'(cnt_q) - 3'(pop) + 3'(vld_p1_q);
    assign issue   = (state_q == STREAM) && (rd_cnt_q < CW'(M3_L)) && (pending < 3'd2);

    assign m3_rd_addr   = (rd_cnt_q >= CW'(M3_L)) ? AW'(M3_L - 1) : AW'(rd_cnt_q);
    assign out_valid    = (cnt_q != 2'd0);
    assign out_data     = out_valid ? fifo_q[rd_ptr_q] : '0;
    assign out_row_last = out_valid && (col_q == COLW'(C - 1));
    assign out_last     = out_valid && (emit_cnt_q == AW'(M3_L - 1));
    assign busy         = (state_q == STREAM);
    assign done         = (state_q == DONE);

    // p1: RAM data for the read issued last cycle lands in the FIFO
    always_ff @(posedge clk) begin
        if (vld_p1_q) begin
            fifo_q[wr_ptr_q] <= data_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            emit_cnt_q <= '0;
            col_q      <= '0;
            vld_p1_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            vld_p1_q <= issue;
            cnt_q    <= cnt_q + 2'(vld_p1_q) - 2'(pop);
            if (issue) begin
                rd_cnt_q <= rd_cnt_q + CW'(1);
            end
            if (vld_p1_q) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q   <= ~rd_ptr_q;
                emit_cnt_q <= emit_cnt_q + AW'(1);
                col_q      <= (col_q == COLW'(C - 1)) ? '0 : col_q + COLW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= STREAM;
                        rd_cnt_q   <= '0;
                        emit_cnt_q <= '0;
                        col_q      <= '0;
                    end
                end
                STREAM: begin
                    if (pop && out_last) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: requant corners, full passes, backpressure, re-arm and abort.
module tb_result_streamer;

    localparam int A        = 16;
    localparam int C        = 24;
    localparam int BITS     = 8;
    localparam int OUT_BITS = 32;
    localparam int SHIFT    = 8;
    localparam int M3_L     = A * C;
    localparam int AW       = $clog2(M3_L);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            out_ready;
    logic [AW-1:0]   m3_rd_addr;
    logic [31:0]     m3_rd_data;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_row_last;
    logic            out_last;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram   [M3_L];
    logic [7:0]  exp_d [M3_L];
    logic [7:0]  got   [M3_L];

    typedef struct {
        logic [31:0] acc;
        logic [7:0]  q;
    } corner_t;
    corner_t corners [8];

    result_streamer #(
        .A(A), .C(C), .BITS(BITS), .OUT_BITS(OUT_BITS), .SHIFT(SHIFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .m3_rd_addr  (m3_rd_addr),
        .m3_rd_data  (m3_rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row_last(out_row_last),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) m3_rd_data <= ram[m3_rd_addr];

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model(input logic [31:0] a);
        longint v;
        v = longint'($signed(a));
        v = v + 128;
        v = v >>> 8;
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
        return 8'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"},    32'(out_valid),    32'd0);
        check({tag, "_data"},     32'(out_data),     32'd0);
        check({tag, "_row_last"}, 32'(out_row_last), 32'd0);
        check({tag, "_last"},     32'(out_last),     32'd0);
        check({tag, "_busy"},     32'(busy),         32'd0);
        check({tag, "_done"},     32'(done),         32'd0);
        check({tag, "_addr"},     32'(m3_rd_addr),   32'd0);
    endtask

    // mode 0: ready high; 1: ready random ~30%; 2: ready low for 10 cycles then high.
    // abort_at >= 0 pulses rst when that element index is presented.
    task automatic run_pass(input int mode, input int abort_at);
        int   idx;
        int   cyc;
        int   first_v;
        int   last_cyc;
        int   gaps;
        bit   seen_valid;
        bit   finished;
        bit   pv_stall;
        logic [10:0] prev;
        idx = 0; cyc = 0; first_v = -1; last_cyc = -1; gaps = 0;
        seen_valid = 0; finished = 0; pv_stall = 0; prev = '0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b0;
        while (!finished && cyc < 5000) begin
            @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 9) < 3);
                default: out_ready = (cyc >= 10);
            endcase
            #1;
            if (cyc == 0) check("busy_in_stream", 32'(busy), 32'd1);
            if (mode == 2 && cyc == 9) begin
                check("stall_addr",  32'(m3_rd_addr), 32'd2);
                check("stall_valid", 32'(out_valid),  32'd1);
                check("stall_head",  32'(out_data),   32'(exp_d[0]));
            end
            if (pv_stall) begin
                check("hold_stable", 32'({out_valid, out_data, out_row_last, out_last}), 32'(prev));
            end
            if (abort_at >= 0 && idx == abort_at && out_valid) begin
                rst = 1'b1;
                start = 1'b0;
                @(negedge clk);
                #1;
                check_reset_state("abort");
                rst = 1'b0;
                finished = 1;
            end else begin
                if (out_valid && first_v < 0) first_v = cyc;
                if (out_valid) seen_valid = 1;
                if (seen_valid && out_ready && !out_valid && idx < M3_L) gaps++;
                if (out_valid && out_ready) begin
                    check($sformatf("data[%0d]", idx), 32'(out_data), 32'(exp_d[idx]));
                    check($sformatf("row_last[%0d]", idx), 32'(out_row_last), 32'((idx % C) == C - 1));
                    check($sformatf("last[%0d]", idx), 32'(out_last), 32'(idx == M3_L - 1));
                    got[idx] = out_data;
                    if (idx == M3_L - 1) last_cyc = cyc;
                    idx++;
                end
                pv_stall = out_valid && !out_ready;
                prev = {out_valid, out_data, out_row_last, out_last};
                if (idx == M3_L) begin
                    @(negedge clk);
                    #1;
                    check("done_after_last", 32'(done), 32'd1);
                    check("busy_after_last", 32'(busy), 32'd0);
                    check("valid_after_last", 32'(out_valid), 32'd0);
                    finished = 1;
                end
            end
            cyc++;
        end
        if (!finished) begin
            check("pass_timeout", 32'(idx), 32'(M3_L));
        end else if (abort_at < 0) begin
            check("elements", 32'(idx), 32'(M3_L));
            if (mode == 0) begin
                check("first_valid_cycle", 32'(first_v), 32'd2);
                check("last_accept_cycle", 32'(last_cyc), 32'(M3_L + 1));
            end
            if (mode != 1) check("bubbles", 32'(gaps), 32'd0);
        end
    endtask

    initial begin
        int  tmp;
        bit  rearm_bad;
        corners[0] = '{32'h0000_1280, 8'h13};
        corners[1] = '{32'hFFFF_FED4, 8'hFF};
        corners[2] = '{32'h0000_9C40, 8'h7F};
        corners[3] = '{32'hFFFF_63C0, 8'h80};
        corners[4] = '{32'h7FFF_FFFF, 8'h7F};
        corners[5] = '{32'h8000_0000, 8'h80};
        corners[6] = '{32'h0000_007F, 8'h00};
        corners[7] = '{32'h0000_0080, 8'h01};
        for (int i = 0; i < M3_L; i++) begin
            if (i % 7 == 3) begin
                ram[i] = $urandom;
            end else begin
                tmp = int'($urandom_range(0, 80000)) - 40000;
                ram[i] = tmp;
            end
        end
        for (int i = 0; i < 8; i++) ram[i] = corners[i].acc;
        for (int i = 0; i < M3_L; i++) exp_d[i] = model(ram[i]);

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // full pass, ready high
        run_pass(0, -1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("corner[%0d]", i), 32'(got[i]), 32'(corners[i].q));
        end

        // start held high after done: no restart
        rearm_bad = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (!done || busy || out_valid) rearm_bad = 1;
        end
        check("rearm_hold", 32'(rearm_bad), 32'd0);
        @(negedge clk);
        start = 1'b0;
        run_pass(0, -1);

        // random backpressure
        @(negedge clk);
        start = 1'b0;
        run_pass(1, -1);

        // stall then release
        @(negedge clk);
        start = 1'b0;
        run_pass(2, -1);

        // reset mid-stream at element 100
        @(negedge clk);
        start = 1'b0;
        run_pass(0, 100);
        rearm_bad = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (out_valid || busy || done) rearm_bad = 1;
        end
        check("quiet_after_abort", 32'(rearm_bad), 32'd0);
        run_pass(0, -1);

        @(negedge clk);
        start = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
